// File: rtl/wb_b3_burst_slave.sv
// Wishbone B3 burst-capable slave memory: classic cycles plus linear/wrap4/8/16
// incrementing bursts over a single word array, with optional first-ack wait states.
module wb_b3_burst_slave #(
  parameter int unsigned DEPTH       = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int WORDS = DEPTH / 4;
  localparam int CW    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, CLASSIC, BURST} state_t;

  state_t          r_state;
  logic [31:0]     r_adr;
  logic [1:0]      r_bte;
  logic            r_burst;
  logic [CW-1:0]   r_cnt;
  logic            r_ack;
  logic            r_err;
  logic [31:0]     r_dat;
  logic [31:0]     r_mem [WORDS];

  logic            w_req;
  logic [31:0]     w_nxt_adr;
  logic            w_cur_oor;
  logic            w_nxt_oor;
  logic [AW-3:0]   w_cur_idx;
  logic [AW-3:0]   w_nxt_idx;
  logic            w_mem_we;

  assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_cur_oor = |r_adr[31:AW];
  assign w_nxt_oor = |w_nxt_adr[31:AW];
  assign w_cur_idx = r_adr[AW-1:2];
  assign w_nxt_idx = w_nxt_adr[AW-1:2];

  // Wrap modes only increment the low word-index bits, so they never leave range.
  always_comb begin
    w_nxt_adr = r_adr + 32'd4;
    case (r_bte)
      2'b01:   w_nxt_adr = {r_adr[31:4], r_adr[3:2] + 2'd1, r_adr[1:0]};
      2'b10:   w_nxt_adr = {r_adr[31:5], r_adr[4:2] + 3'd1, r_adr[1:0]};
      2'b11:   w_nxt_adr = {r_adr[31:6], r_adr[5:2] + 4'd1, r_adr[1:0]};
      default: w_nxt_adr = r_adr + 32'd4;
    endcase
  end

  // A beat transfers on the edge that closes an ack cycle with cyc&stb still high.
  assign w_mem_we = wb_rst_n_i & wb_cyc_i & wb_stb_i & wb_we_i & r_ack &
                    ((r_state == CLASSIC) | (r_state == BURST));

  always_ff @(posedge wb_clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) r_mem[w_cur_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= 32'd0;
      r_cnt   <= '0;
      r_adr   <= 32'd0;
      r_bte   <= 2'b00;
      r_burst <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (!wb_cyc_i) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_req) begin
              r_adr   <= wb_adr_i;
              r_bte   <= wb_bte_i;
              r_burst <= (wb_cti_i == 3'b010);
              r_cnt   <= '0;
              if (WAIT_STATES > 0)             r_state <= WAIT;
              else if (wb_cti_i == 3'b010)     r_state <= BURST;
              else                             r_state <= CLASSIC;
            end
          end
          WAIT: begin
            if (r_cnt == CW'(WAIT_STATES - 1)) r_state <= r_burst ? BURST : CLASSIC;
            else                               r_cnt   <= r_cnt + CW'(1);
          end
          CLASSIC: begin
            if (!r_ack) begin
              if (w_cur_oor) begin
                r_err   <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_ack <= 1'b1;
                r_dat <= r_mem[w_cur_idx];
              end
            end else begin
              r_state <= IDLE;
            end
          end
          BURST: begin
            if (!r_ack) begin
              if (w_cur_oor) begin
                r_err   <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_ack <= 1'b1;
                r_dat <= r_mem[w_cur_idx];
              end
            end else if (!wb_stb_i) begin
              r_state <= IDLE;
            end else if (wb_cti_i != 3'b010) begin
              r_state <= IDLE;
            end else begin
              // Prefetch the next beat's word so acks stay back-to-back.
              r_adr <= w_nxt_adr;
              if (w_nxt_oor) begin
                r_err   <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_ack <= 1'b1;
                r_dat <= r_mem[w_nxt_idx];
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_b3_burst_slave.sv
// Directed bench for wb_b3_burst_slave: one zero-wait-state instance and one
// three-wait-state instance sharing the bus, selected by dsel.
module tb_wb_b3_burst_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb, dsel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1, err0, err1, rty0, rty1;
  logic [31:0] dat_o;
  logic        ack, err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wdata [16];
  logic [31:0] rdata [16];
  int          lat, nack;
  bit          errseen, tail_ack;

  always #5 clk = ~clk;

  wb_b3_burst_slave #(.DEPTH(32'h1000), .WAIT_STATES(0)) u0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc & ~dsel), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat0), .wb_ack_o(ack0),
    .wb_err_o(err0), .wb_rty_o(rty0));

  wb_b3_burst_slave #(.DEPTH(32'h1000), .WAIT_STATES(3)) u1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc & dsel), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat1), .wb_ack_o(ack1),
    .wb_err_o(err1), .wb_rty_o(rty1));

  assign dat_o = dsel ? dat1 : dat0;
  assign ack   = dsel ? ack1 : ack0;
  assign err   = dsel ? err1 : err0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic classic(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output int l, output logic [31:0] rd,
                         output bit ga, output bit ge, output bit one);
    adr = a; dat_i = d; sel = s; we = w; cti = 3'b000; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1; l = 0;
    do begin tick(); l++; end while (!ack && !err && l < 30);
    ga = ack; ge = err; rd = dat_o;
    tick();
    one = !ack && !err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic burst(input logic [31:0] a, input logic [1:0] b, input int n, input logic w);
    adr = a; bte = b; we = w; sel = 4'hF; dat_i = wdata[0];
    cti = (n == 1) ? 3'b111 : 3'b010;
    cyc = 1'b1; stb = 1'b1;
    lat = 0; nack = 0; errseen = 0;
    do begin tick(); lat++; end while (!ack && !err && lat < 30);
    if (err) errseen = 1;
    while (ack && nack < n) begin
      rdata[nack] = dat_o;
      dat_i = wdata[nack];
      cti = (nack == n - 1) ? 3'b111 : 3'b010;
      tick();
      nack++;
      if (err) errseen = 1;
    end
    tail_ack = ack;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dsel = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_i = '0; sel = '0; cti = '0; bte = '0;
    repeat (3) tick();
    n_cmp++;
    if ({ack0, err0, rty0, ack1, err1, rty1} !== 6'b0 || dat0 !== 32'd0 || dat1 !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ack/err/rty=%b dat0=%h dat1=%h, want 0",
               {ack0, err0, rty0, ack1, err1, rty1}, dat0, dat1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_classic();
    int l; logic [31:0] rd; bit ga, ge, one;
    classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, l, rd, ga, ge, one);
    n_cmp++;
    if (!(l == 2 && ga && !ge && one)) begin
      n_bad++; $display("FAIL classic_write: got lat=%0d ack=%0b err=%0b one=%0b, want 2 1 0 1", l, ga, ge, one);
    end
    classic(32'h10, 1'b0, 32'h0, 4'hF, l, rd, ga, ge, one);
    n_cmp++;
    if (!(l == 2 && ga && !ge && one) || rd !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL classic_read: got lat=%0d ack=%0b one=%0b dat=%h, want 2 1 1 deadbeef", l, ga, one, rd);
    end
  endtask

  task automatic test_byte_lane();
    int l; logic [31:0] rd; bit ga, ge, one;
    classic(32'h10, 1'b1, 32'h00AA0000, 4'b0100, l, rd, ga, ge, one);
    classic(32'h10, 1'b0, 32'h0, 4'hF, l, rd, ga, ge, one);
    n_cmp++;
    if (rd !== 32'hDEAABEEF) begin
      n_bad++; $display("FAIL byte_lane: got %h, want deaabeef", rd);
    end
  endtask

  task automatic test_wrap4();
    logic [31:0] exp4 [4];
    exp4 = '{32'h18, 32'h1C, 32'h10, 32'h14};
    for (int i = 0; i < 4; i++) wdata[i] = 32'h10 + 32'(4 * i);
    burst(32'h10, 2'b00, 4, 1'b1);
    burst(32'h18, 2'b01, 4, 1'b0);
    n_cmp++;
    if (lat != 2 || nack != 4 || tail_ack || errseen) begin
      n_bad++; $display("FAIL wrap4_acks: got lat=%0d acks=%0d tail=%0b err=%0b, want 2 4 0 0", lat, nack, tail_ack, errseen);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rdata[i] !== exp4[i]) begin
        n_bad++; $display("FAIL wrap4_beat%0d: got %h, want %h", i, rdata[i], exp4[i]);
      end
    end
  endtask

  task automatic wrap8_run(input int want_lat);
    logic [31:0] ord [8];
    ord = '{32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h40, 32'h44, 32'h48};
    for (int i = 0; i < 8; i++) wdata[i] = 32'hA500_0040 + 32'(4 * i);
    burst(32'h40, 2'b00, 8, 1'b1);
    n_cmp++;
    if (lat != want_lat || nack != 8 || tail_ack) begin
      n_bad++; $display("FAIL linear8_write: got lat=%0d acks=%0d tail=%0b, want %0d 8 0", lat, nack, tail_ack, want_lat);
    end
    burst(32'h4C, 2'b10, 8, 1'b0);
    n_cmp++;
    if (lat != want_lat || nack != 8 || tail_ack) begin
      n_bad++; $display("FAIL wrap8_acks: got lat=%0d acks=%0d tail=%0b, want %0d 8 0", lat, nack, tail_ack, want_lat);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rdata[i] !== (32'hA500_0000 | ord[i])) begin
        n_bad++; $display("FAIL wrap8_beat%0d: got %h, want %h", i, rdata[i], 32'hA500_0000 | ord[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    int l; logic [31:0] rd; bit ga, ge, one;
    dsel = 1'b1;
    classic(32'h20, 1'b1, 32'h12345678, 4'hF, l, rd, ga, ge, one);
    n_cmp++;
    if (!(l == 5 && ga && one)) begin
      n_bad++; $display("FAIL ws3_write: got lat=%0d ack=%0b one=%0b, want 5 1 1", l, ga, one);
    end
    classic(32'h20, 1'b0, 32'h0, 4'hF, l, rd, ga, ge, one);
    n_cmp++;
    if (!(l == 5 && ga && one) || rd !== 32'h12345678) begin
      n_bad++; $display("FAIL ws3_read: got lat=%0d ack=%0b dat=%h, want 5 1 12345678", l, ga, rd);
    end
    wrap8_run(5);
    dsel = 1'b0;
  endtask

  task automatic test_out_of_range();
    int l; logic [31:0] rd; bit ga, ge, one;
    classic(32'h1000, 1'b0, 32'h0, 4'hF, l, rd, ga, ge, one);
    n_cmp++;
    if (!(l == 2 && !ga && ge && one)) begin
      n_bad++; $display("FAIL oor_classic: got lat=%0d ack=%0b err=%0b one=%0b, want 2 0 1 1", l, ga, ge, one);
    end
    wdata[0] = 32'hCAFE0FF8; wdata[1] = 32'hCAFE0FFC;
    burst(32'hFF8, 2'b00, 2, 1'b1);
    burst(32'hFF8, 2'b00, 3, 1'b0);
    n_cmp++;
    if (nack != 2 || !errseen) begin
      n_bad++; $display("FAIL oor_burst_end: got acks=%0d err=%0b, want 2 1", nack, errseen);
    end
    n_cmp++;
    if (rdata[0] !== 32'hCAFE0FF8 || rdata[1] !== 32'hCAFE0FFC) begin
      n_bad++; $display("FAIL oor_burst_data: got %h %h, want cafe0ff8 cafe0ffc", rdata[0], rdata[1]);
    end
  endtask

  // mode 0: drop cyc on beat 2; mode 1: assert reset on beat 2.
  task automatic interrupted(input logic [31:0] base, input int mode);
    int l;
    for (int i = 0; i < 8; i++) wdata[i] = 32'h1111_0000 | (base + 32'(4 * i));
    burst(base, 2'b00, 8, 1'b1);
    adr = base; bte = 2'b00; we = 1'b1; sel = 4'hF; cti = 3'b010;
    dat_i = 32'h2222_0000 | base; cyc = 1'b1; stb = 1'b1; l = 0;
    do begin tick(); l++; end while (!ack && l < 30);
    for (int b = 0; b < 2; b++) begin
      dat_i = 32'h2222_0000 | (base + 32'(4 * b));
      tick();
    end
    dat_i = 32'h2222_0000 | (base + 32'd8);
    if (mode == 0) begin cyc = 1'b0; stb = 1'b0; end
    else rst_n = 1'b0;
    tick();
    n_cmp++;
    if (ack0 !== 1'b0 || err0 !== 1'b0 || (mode == 1 && dat0 !== 32'd0)) begin
      n_bad++; $display("FAIL interrupt%0d_outputs: got ack=%0b err=%0b dat=%h, want 0 0", mode, ack0, err0, dat0);
    end
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    burst(base, 2'b00, 8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = ((i < 2) ? 32'h2222_0000 : 32'h1111_0000) | (base + 32'(4 * i));
      n_cmp++;
      if (rdata[i] !== e) begin
        n_bad++; $display("FAIL interrupt%0d_word%0d: got %h, want %h", mode, i, rdata[i], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_classic();
    test_byte_lane();
    test_wrap4();
    wrap8_run(2);
    test_wait_states();
    test_out_of_range();
    interrupted(32'h80, 0);
    interrupted(32'hC0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/wb_b3_burst_slave.md
Name: wb_b3_burst_slave

Overview:
- Wishbone B3 slave memory; the responder end of the registered-feedback (B3_REGISTERED_FEEDBACK) instruction and data bus masters.
- Serves classic single cycles and incrementing bursts with linear/wrap4/wrap8/wrap16 BTE from one 32-bit word array.
- Sits on a slave port of the wishbone interconnect, alongside main RAM, as a fast scratchpad and as the burst-compliance target for CPU cache refills.

Parameters:
DEPTH, 32'h00001000, memory size in bytes; power of two, >= 64.
WAIT_STATES, 0, extra cycles inserted before the first ack of every access (classic or burst).

Ports:
wb_clk_i  in  1  clock.
wb_rst_n_i  in  1  synchronous active-low reset.
wb_adr_i  in  32  byte address.
wb_dat_i  in  32  write data.
wb_sel_i  in  4  byte enables; bit n selects dat[8n+7:8n].
wb_we_i  in  1  write enable.
wb_cyc_i  in  1  cycle valid.
wb_stb_i  in  1  strobe.
wb_cti_i  in  3  cycle type: 000 classic, 001 const, 010 incr burst, 111 end of burst.
wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
wb_dat_o  out  32  read data; valid while wb_ack_o=1.
wb_ack_o  out  1  beat acknowledge.
wb_err_o  out  1  error acknowledge (out-of-range access).
wb_rty_o  out  1  tied 0.

Behaviour:
- Clock/reset: one clock, wb_clk_i. Reset is synchronous and active-low on wb_rst_n_i.
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, state IDLE, wait counter 0. Memory contents are not reset.
- Array: DEPTH/4 words, indexed by adr[log2(DEPTH)-1:2].
- Range check: out of range when adr[31:log2(DEPTH)] != 0.
- Request: cyc&stb high while ack and err are both low.
- States: IDLE, WAIT, CLASSIC, BURST.
- IDLE:
  - On a request, latch adr, bte, and burst mode (cti==010; all other cti values are classic).
  - Go to WAIT if WAIT_STATES>0, else to CLASSIC or BURST.
- WAIT: count WAIT_STATES cycles, then go to CLASSIC or BURST.
- First-ack latency: request sampled at edge N gives ack (or err) high in the cycle after edge N+1+WAIT_STATES.
- Out-of-range first beat: err instead of ack for one cycle, no write, return to IDLE.
- CLASSIC:
  - ack high for exactly one cycle, then IDLE.
  - Write: on the ack cycle, write bytes selected by wb_sel_i at the latched address.
  - Read: wb_dat_o holds the word at the latched address.
  - The slave cannot respond to a new request in the cycle immediately after ack.
- BURST:
  - ack stays high every cycle while cyc&stb=1; each acked beat is one transfer.
  - The internal address advances after each acked beat.
  - Linear: +4.
  - wrap4: adr[3:2]+1, upper bits fixed.
  - wrap8: adr[4:2]+1, upper bits fixed.
  - wrap16: adr[5:2]+1, upper bits fixed.
  - Read data for the next beat is pre-fetched so that back-to-back beats have zero bubbles.
  - wb_adr_i is ignored after the first beat; the internal address is authoritative.
  - Writes use wb_dat_i and wb_sel_i of the acked cycle.
- Burst termination:
  - A beat acked with cti==111, or with cti!=010: last beat. ack goes low next cycle, state IDLE.
  - stb low mid-burst: ack goes low next cycle, state IDLE, nothing transferred that cycle. A later stb restarts as a new access with full first-ack latency.
  - Linear burst whose next address leaves the range: that beat gets err instead of ack, no write, state IDLE. Wrap bursts cannot leave range.
- cyc low in any state: return to IDLE, ack/err low next cycle, no write.
- Reset asserted mid-burst: IDLE next edge, outputs at reset values, no write in the reset cycle.
- ack and err are never high in the same cycle.
- wb_dat_o keeps its last value when ack is low.

Test Plan:
- Classic write 0xDEADBEEF, sel=4'b1111, to 0x10, then classic read of 0x10 with WAIT_STATES=0 → read ack 2 cycles after stb; dat_o=0xDEADBEEF; each ack exactly 1 cycle.
- Byte-lane write sel=4'b0100, dat=0x00AA0000, to 0x10 → read gives 0xDEAABEEF.
- Wrap4 read burst from 0x18, words preloaded with their own address → beats return 0x18, 0x1C, 0x10, 0x14; acks contiguous; ack drops the cycle after the cti=111 beat.
- Linear write burst of 8 beats from 0x40, then wrap8 read from 0x4C → values correct in order 0x4C, 0x50, 0x54, 0x58, 0x5C, 0x40, 0x44, 0x48. With WAIT_STATES=3, first ack 5 cycles after stb.
- Out of range:
  - Classic read of DEPTH (0x1000) → err for one cycle, no ack.
  - Linear read burst from DEPTH-8 → acks at 0xFF8 and 0xFFC, err on the third beat, no third ack.
- Interruptions:
  - cyc dropped on beat 2 of an 8-beat write burst → only beats 0–1 are written.
  - wb_rst_n_i=0 mid-burst → ack=0 next edge, no further writes.
